// File: rtl/cyclic_flush_sched.sv
// Walks the selected cyclic cache banks lowest-first: hold off the reqMux, pulse csr_flush, wait for write-back.
// Optional per-bank hang timeout enabled by defining CYCLIC_FLUSH_TIMEOUT_EN.
module cyclic_flush_sched #(
  parameter int BANK_NUM   = 4,
  parameter int BANK_IDX_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
  parameter int TIMEOUT_W  = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  input  logic [BANK_NUM-1:0]   flush_mask,
  input  logic [BANK_NUM-1:0]   bank_ready,
  input  logic [BANK_NUM-1:0]   bank_idle,
  output logic [BANK_NUM-1:0]   bank_hold,
  output logic [BANK_NUM-1:0]   bank_flush,
  output logic                  busy,
  output logic                  done,
  output logic [BANK_IDX_W-1:0] cur_bank,
  output logic                  err,
  output logic [BANK_IDX_W-1:0] err_bank
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_HOLD, S_PULSE, S_WAIT_LO, S_WAIT_HI, S_NEXT, S_FIN
  } state_t;

  if (TIMEOUT < 1 || 64'(TIMEOUT) >= (64'(1) << TIMEOUT_W)) begin : g_bad_cfg
    $error("cyclic_flush_sched: TIMEOUT must be in 1 .. 2**TIMEOUT_W-1");
  end

  state_t                r_state, w_state_nxt;
  logic [BANK_NUM-1:0]   r_rem_mask;
  logic [BANK_IDX_W-1:0] r_cur_bank;
  logic                  r_step;   // set from the second cycle spent in HOLD or WAIT_LO
  logic                  r_done;
  logic [BANK_IDX_W-1:0] w_low_idx;
  logic                  w_cur_ready;
  logic                  w_cur_idle;
  logic                  w_owns;
  logic                  w_timeout;

  assign w_cur_ready = bank_ready[r_cur_bank];
  assign w_cur_idle  = bank_idle[r_cur_bank];

  always_comb begin
    w_low_idx = '0;
    for (int i = BANK_NUM - 1; i >= 0; i--) begin
      if (r_rem_mask[i]) w_low_idx = BANK_IDX_W'(i);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (flush_req) w_state_nxt = S_SEL;
      S_SEL:     w_state_nxt = (r_rem_mask == '0) ? S_FIN : S_HOLD;
      S_HOLD:    if (r_step && w_cur_idle && w_cur_ready) w_state_nxt = S_PULSE;
      S_PULSE:   w_state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!w_cur_ready) w_state_nxt = S_WAIT_HI;
        else if (r_step)  w_state_nxt = S_NEXT;
      end
      S_WAIT_HI: if (w_cur_ready || w_timeout) w_state_nxt = S_NEXT;
      S_NEXT:    w_state_nxt = S_SEL;
      S_FIN:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rem_mask <= '0;
      r_cur_bank <= '0;
      r_step     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= (w_state_nxt == r_state) && (r_state == S_HOLD || r_state == S_WAIT_LO);
      r_done  <= (r_state == S_FIN);
      if (r_state == S_IDLE && flush_req) r_rem_mask <= flush_mask;
      if (r_state == S_SEL && r_rem_mask != '0) r_cur_bank <= w_low_idx;
      if (r_state == S_NEXT) r_rem_mask[r_cur_bank] <= 1'b0;
    end
  end

  assign w_owns = (r_state == S_HOLD) || (r_state == S_PULSE) ||
                  (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);

  always_comb begin
    bank_hold  = '0;
    bank_flush = '0;
    for (int i = 0; i < BANK_NUM; i++) begin
      bank_hold[i]  = w_owns && (r_cur_bank == BANK_IDX_W'(i));
      bank_flush[i] = (r_state == S_PULSE) && (r_cur_bank == BANK_IDX_W'(i));
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign cur_bank = r_cur_bank;

`ifdef CYCLIC_FLUSH_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]  r_timer;
  logic                  r_err;
  logic [BANK_IDX_W-1:0] r_err_bank;

  assign w_timeout = (r_state == S_WAIT_HI) && !w_cur_ready &&
                     (r_timer == TIMEOUT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer    <= '0;
      r_err      <= 1'b0;
      r_err_bank <= '0;
    end else begin
      r_timer <= (r_state == S_WAIT_HI) ? r_timer + 1'b1 : '0;
      if (r_state == S_IDLE && flush_req) begin
        r_err      <= 1'b0;
        r_err_bank <= '0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
        if (!r_err) r_err_bank <= r_cur_bank;
      end
    end
  end

  assign err      = r_err;
  assign err_bank = r_err_bank;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
  assign err_bank  = '0;
`endif

endmodule

// File: doc/cyclic_flush_sched.md
Name: cyclic_flush_sched

Overview:
- Sequences cache flushes across the cyclic cache banks.
- A CSR write starts the sequence. The block then walks the selected banks one at a time, lowest index first.
- For each bank it holds off new requests from the cyclic request mux, pulses that bank's csr_flush, and waits for the bank to finish writing back to AXI.
- It sits between the CSR block / cyclic reqMux and the csr_flush inputs of the cyclic cache bank array.

Parameters:
- BANK_NUM, 4, number of cyclic cache banks (equals BANK_NUM[MEM_TYPE_CYCLIC]).
- BANK_IDX_W, $clog2(BANK_NUM) (min 1), width of bank index outputs.
- TIMEOUT_W, 16, width of per-bank timeout counter.
- TIMEOUT, 4096, cycles allowed in WAIT_HI before a bank is declared hung (TIMEOUT < 2^TIMEOUT_W).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- flush_req  in  1  single-cycle start pulse from CSR.
- flush_mask  in  BANK_NUM  banks to flush; sampled only on an accepted flush_req.
- bank_ready  in  BANK_NUM  per-bank cache ready; low while the bank is busy or flushing.
- bank_idle  in  BANK_NUM  per-bank reqMux has no accepted-but-unreturned request.
- bank_hold  out  BANK_NUM  to reqMux: stop granting new requests to bank i.
- bank_flush  out  BANK_NUM  csr_flush to bank i; one-cycle pulse.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- cur_bank  out  BANK_IDX_W  bank currently being processed.
- err  out  1  sticky timeout flag; cleared on the next accepted flush_req.
- err_bank  out  BANK_IDX_W  first bank that timed out.

Behaviour:
- Reset: all outputs are 0, state = IDLE, rem_mask = 0, timer = 0.
- States: IDLE, SEL, HOLD, PULSE, WAIT_LO, WAIT_HI, NEXT, FIN.
- IDLE:
  - flush_req=1 → latch rem_mask=flush_mask, clear err/err_bank, busy=1 next cycle, go SEL.
  - flush_req while not IDLE is ignored.
- SEL:
  - rem_mask==0 → FIN.
  - Otherwise cur_bank = lowest set bit of rem_mask → HOLD.
- HOLD:
  - bank_hold[cur_bank]=1.
  - Wait until bank_idle[cur_bank] & bank_ready[cur_bank] are both 1 in the same cycle → PULSE.
  - The first possible exit is the cycle after entry, so hold is registered for ≥1 cycle before the idle check.
- PULSE: bank_flush[cur_bank]=1 for exactly this cycle → WAIT_LO; hold stays asserted.
- WAIT_LO:
  - bank_ready[cur_bank]=0 → WAIT_HI, timer=0.
  - Ready still high after 2 cycles in WAIT_LO → NEXT (clean bank, flush completed with no write-back).
- WAIT_HI:
  - timer increments each cycle.
  - bank_ready[cur_bank]=1 → NEXT.
  - Timeout handling: see Optional Feature.
- NEXT: clear rem_mask[cur_bank], deassert bank_hold[cur_bank] → SEL.
- FIN: done=1 for one cycle, busy=0 next cycle → IDLE.
- Latency: flush_req with mask=0 gives busy high for 2 cycles (SEL, FIN) and done 3 cycles after flush_req.
- At most one bit of bank_hold and one bit of bank_flush is set in any cycle.
- Mask bits ≥ BANK_NUM do not exist; the mask is exactly BANK_NUM wide.
- Reset mid-sequence: rst=1 returns to IDLE the next cycle and clears hold/flush/busy. Banks in mid-flush are not tracked.

Optional Feature:
- Macro CYCLIC_FLUSH_TIMEOUT_EN.
- Defined:
  - In WAIT_HI, timer reaching TIMEOUT-1 with ready still low → set err=1.
  - err_bank=cur_bank if err was 0.
  - Go to NEXT, releasing hold; the sequence continues with the remaining banks.
- Undefined:
  - Timer logic is absent; WAIT_HI waits indefinitely.
  - err and err_bank are tied to 0.

Test Plan:
- rst, then flush_req with mask=4'b0000 → busy=1 for 2 cycles, done pulse 3 cycles after req, no bank_flush/bank_hold activity.
- mask=4'b1010; all banks idle/ready; bank 1 drops ready 1 cycle after its flush for 10 cycles, bank 3 stays ready (clean) →
  - bank_flush[1] pulses first, then bank_flush[3].
  - cur_bank goes 1 then 3.
  - bank_hold[1] is low before bank_hold[3] goes high.
  - one done pulse.
- mask=4'b0001 with bank_idle[0]=0 for 20 cycles → bank_hold[0]=1 throughout, bank_flush[0] is not asserted until the cycle after idle goes high.
- Second flush_req (mask=4'b1111) during an active sequence → ignored; only the original mask's banks flush; exactly one done.
- CYCLIC_FLUSH_TIMEOUT_EN, TIMEOUT=16, mask=4'b0110, bank 1 holds ready=0 forever →
  - err=1, err_bank=1 after 16 WAIT_HI cycles.
  - bank 2 is still flushed.
  - done pulses; err persists until the next flush_req.
- rst asserted during WAIT_HI of bank 2 → next cycle busy=0, bank_hold=0, state IDLE; a new flush_req (mask=4'b0100) completes normally.
